// File: rtl/lm70_pkg.sv
// rtl/lm70_pkg.sv - shared encodings and constants for the LM70 SPI responder
package lm70_pkg;

  localparam int LM70_FRAME_W = 16;
  localparam int LM70_TEMP_W  = 11;

  localparam logic [4:0]              LM70_PAD         = 5'b11111;
  localparam logic [7:0]              LM70_SHDN_CMD    = 8'hFF;
  localparam logic [LM70_FRAME_W-1:0] LM70_MFG_ID_DEF  = 16'h8101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } lm70_state_e;

  // Word presented on SIO during the read phase: ID in shutdown, else padded temperature.
  function automatic logic [LM70_FRAME_W-1:0] lm70_read_frame(
    input logic                        shdn,
    input logic [LM70_TEMP_W-1:0]      temp,
    input logic [LM70_FRAME_W-1:0]     mfg_id
  );
    lm70_read_frame = shdn ? mfg_id : {temp, LM70_PAD};
  endfunction

endpackage

// File: rtl/lm70_spi_responder_sync_edge_det.sv
// rtl/lm70_spi_responder_sync_edge_det.sv - multi-flop synchronizer with rise/fall pulses
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the async input through the chain and keep a delayed copy of the synced level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/lm70_spi_responder.sv
// rtl/lm70_spi_responder.sv - LM70 sensor SPI slave: 16-bit read frame then 16-bit command write
module lm70_spi_responder
  import lm70_pkg::*;
#(
  parameter int                      SYNC_STAGES = 2,
  parameter logic [LM70_FRAME_W-1:0] MFG_ID      = LM70_MFG_ID_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs_n,
  input  logic                   sck,
  input  logic                   sio_in,
  output logic                   sio_out,
  output logic                   sio_oe,
  input  logic [LM70_TEMP_W-1:0] temp_in,
  input  logic                   temp_load,
  output logic                   shutdown,
  output logic                   frame_done
);

  localparam logic [4:0] BIT_LAST = 5'd15;
  localparam logic [4:0] BIT_FULL = 5'd16;

  logic w_cs_level_unused;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_sck_level_unused;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_sio_sync;
  logic w_sio_rise_unused;
  logic w_sio_fall_unused;

  lm70_state_e r_state;
  lm70_state_e w_next_state;

  logic [LM70_FRAME_W-1:0] r_shift_reg;
  logic [LM70_FRAME_W-1:0] r_cmd_shift;
  logic [4:0]              r_bit_cnt;
  logic [LM70_TEMP_W-1:0]  r_temp_reg;
  logic                    r_shutdown;
  logic                    r_sio_out;
  logic                    r_sio_oe;
  logic                    r_frame_done;

  logic w_sio_out_d;
  logic w_sio_oe_d;
  logic w_frame_done_d;
  logic w_cs_abort;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (cs_n),
    .o_level (w_cs_level_unused),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (sck),
    .o_level (w_sck_level_unused),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sio (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (sio_in),
    .o_level (w_sio_sync),
    .o_rise  (w_sio_rise_unused),
    .o_fall  (w_sio_fall_unused)
  );

  // A chip-select release ends any active frame and takes priority over sck edges.
  assign w_cs_abort = w_cs_rise && (r_state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: cs release, then cs assert (restart even if not idle), then bit progress.
  always_comb begin
    w_next_state = r_state;
    if (w_cs_abort) begin
      w_next_state = ST_IDLE;
    end else if (w_cs_fall) begin
      w_next_state = ST_READ;
    end else begin
      case (r_state)
        ST_READ:  if (w_sck_fall && (r_bit_cnt == BIT_LAST)) w_next_state = ST_WRITE;
        ST_WRITE: if (r_bit_cnt == BIT_FULL)                  w_next_state = ST_DONE;
        default:  w_next_state = r_state;
      endcase
    end
  end

  // Output decode; the pad is only driven while the read word is being shifted out.
  always_comb begin
    w_sio_oe_d     = (r_state == ST_READ);
    w_sio_out_d    = (r_state == ST_READ) ? r_shift_reg[LM70_FRAME_W-1] : 1'b0;
    w_frame_done_d = w_cs_abort && ((r_state == ST_WRITE) || (r_state == ST_DONE));
  end

  // Registered outputs keep the pad free of decode glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sio_out    <= 1'b0;
      r_sio_oe     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sio_out    <= w_sio_out_d;
      r_sio_oe     <= w_sio_oe_d;
      r_frame_done <= w_frame_done_d;
    end
  end

  // Temperature holding register; the read word is snapshotted at frame start so loads never tear it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_temp_reg <= '0;
    end else if (temp_load) begin
      r_temp_reg <= temp_in;
    end
  end

  // Shift datapath, bit counter and command application.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift_reg <= '0;
      r_cmd_shift <= '0;
      r_bit_cnt   <= '0;
      r_shutdown  <= 1'b0;
    end else if (w_cs_abort) begin
      r_bit_cnt <= '0;
    end else if (w_cs_fall) begin
      r_shift_reg <= lm70_read_frame(r_shutdown, r_temp_reg, MFG_ID);
      r_bit_cnt   <= '0;
    end else begin
      case (r_state)
        ST_READ: begin
          if (w_sck_fall) begin
            r_shift_reg <= {r_shift_reg[LM70_FRAME_W-2:0], 1'b0};
            r_bit_cnt   <= (r_bit_cnt == BIT_LAST) ? 5'd0 : r_bit_cnt + 5'd1;
          end
        end
        ST_WRITE: begin
          if (r_bit_cnt == BIT_FULL) begin
            r_shutdown <= (r_cmd_shift[7:0] == LM70_SHDN_CMD);
          end else if (w_sck_rise) begin
            r_cmd_shift <= {r_cmd_shift[LM70_FRAME_W-2:0], w_sio_sync};
            r_bit_cnt   <= r_bit_cnt + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sio_out    = r_sio_out;
  assign sio_oe     = r_sio_oe;
  assign shutdown   = r_shutdown;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lm70_spi_responder.sv
// tb/tb_lm70_spi_responder.sv - randomized master driving the LM70 responder against a behavioural sensor model
module tb_lm70_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        sck = 1'b0;
  logic        sio_in = 1'b0;
  logic        sio_out;
  logic        sio_oe;
  logic [10:0] temp_in = '0;
  logic        temp_load = 1'b0;
  logic        shutdown;
  logic        frame_done;

  int checks = 0;
  int errs   = 0;

  int fd_cnt = 0;
  int oe_write_err = 0;
  bit in_write = 1'b0;

  // Behavioural sensor state.
  logic [10:0] m_temp = '0;
  bit          m_shdn = 1'b0;

  lm70_spi_responder #(.SYNC_STAGES(2), .MFG_ID(16'h8101)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .sck        (sck),
    .sio_in     (sio_in),
    .sio_out    (sio_out),
    .sio_oe     (sio_oe),
    .temp_in    (temp_in),
    .temp_load  (temp_load),
    .shutdown   (shutdown),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (in_write && sio_oe) oe_write_err <= oe_write_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_temp(input logic [10:0] v);
    temp_in   = v;
    temp_load = 1'b1;
    clks(1);
    temp_load = 1'b0;
    m_temp    = v;
  endtask

  function automatic logic [15:0] model_frame();
    return m_shdn ? 16'h8101 : {m_temp, 5'b11111};
  endfunction

  // One chip-select transaction; sck is 16 clk per period.
  task automatic xfer(input int n_read, input int n_write, input logic [15:0] wdata,
                      input int load_bit, input logic [10:0] load_val);
    logic [15:0] exp_rd;
    logic [15:0] rd;
    exp_rd = model_frame();
    rd     = '0;
    fd_cnt = 0;
    oe_write_err = 0;
    cs_n = 1'b0;
    clks(3);
    check("oe_lat_early", {31'd0, sio_oe}, 32'd0);
    clks(1);
    check("oe_lat", {31'd0, sio_oe}, 32'd1);
    clks(4);
    for (int i = 0; i < n_read; i++) begin
      if (i == load_bit) load_temp(load_val);
      sio_in = 1'($urandom);
      sck = 1'b1;
      rd = {rd[14:0], sio_out};
      clks(8);
      sck = 1'b0;
      clks(8);
    end
    check("read", {16'd0, rd}, {16'd0, exp_rd >> (16 - n_read)});
    for (int i = 0; i < n_write; i++) begin
      sio_in = (i < 16) ? wdata[15 - i] : 1'($urandom);
      clks(2);
      sck = 1'b1;
      in_write = 1'b1;
      clks(8);
      sck = 1'b0;
      clks(8);
    end
    clks(2);
    cs_n = 1'b1;
    in_write = 1'b0;
    clks(8);
    if (n_read == 16 && n_write >= 16) m_shdn = (wdata[7:0] == 8'hFF);
    check("oe_after_cs", {31'd0, sio_oe}, 32'd0);
    check("frame_done", fd_cnt, (n_read == 16) ? 32'd1 : 32'd0);
    check("oe_write", oe_write_err, 32'd0);
    check("shutdown", {31'd0, shutdown}, {31'd0, m_shdn});
  endtask

  initial begin
    clks(4);
    check("rst_sio_out", {31'd0, sio_out}, 32'd0);
    check("rst_sio_oe", {31'd0, sio_oe}, 32'd0);
    check("rst_shutdown", {31'd0, shutdown}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    clks(4);

    // Positive temperature, command 0 keeps sensor active.
    load_temp(11'h064);
    check("frame_25c", {16'd0, model_frame()}, 32'h0C9F);
    xfer(16, 16, 16'h0000, -1, '0);

    // Negative temperature with a mid-frame load that must land in the next frame only.
    load_temp(11'h79C);
    xfer(16, 16, 16'h0000, 7, 11'h000);
    xfer(16, 16, 16'h0000, -1, '0);

    // Shutdown entry, ID readback, exit.
    xfer(16, 16, 16'h00FF, -1, '0);
    xfer(16, 16, 16'h0000, -1, '0);
    load_temp(11'h123);
    xfer(16, 16, 16'h1234, -1, '0);

    // Read aborted after 5 bits, then a full frame.
    xfer(5, 0, 16'h0000, -1, '0);
    xfer(16, 0, 16'h0000, -1, '0);

    // Aborted write, then extra sck pulses in the done phase.
    xfer(16, 10, 16'h00FF, -1, '0);
    xfer(16, 20, 16'h5A00, -1, '0);

    // Reset in the middle of a read while in shutdown.
    xfer(16, 16, 16'hABFF, -1, '0);
    cs_n = 1'b0;
    clks(8);
    for (int i = 0; i < 3; i++) begin
      sck = 1'b1; clks(8);
      sck = 1'b0; clks(8);
    end
    rst_n = 1'b0;
    clks(1);
    rst_n = 1'b1;
    check("mid_rst_sio_oe", {31'd0, sio_oe}, 32'd0);
    check("mid_rst_sio_out", {31'd0, sio_out}, 32'd0);
    check("mid_rst_shutdown", {31'd0, shutdown}, 32'd0);
    check("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    cs_n = 1'b1;
    clks(16);
    m_shdn = 1'b0;
    m_temp = '0;
    xfer(16, 16, 16'h0000, -1, '0);

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      int          nr;
      int          nw;
      int          lb;
      logic [15:0] wd;
      logic [10:0] tv;
      tv = 11'($urandom);
      if ($urandom_range(0, 1) == 0) load_temp(tv);
      wd = 16'($urandom);
      if ($urandom_range(0, 1) == 0) wd[7:0] = 8'hFF;
      nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      case ($urandom_range(0, 3))
        0:       nw = 0;
        1:       nw = 10;
        2:       nw = 16;
        default: nw = 20;
      endcase
      if (nr < 16) nw = 0;
      lb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nr - 1)) : -1;
      xfer(nr, nw, wd, lb, 11'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
